// File: rtl/fp_compare_pipe_if.sv
// rtl/fp_compare_pipe_if.sv - operand and result stream bundle for fp_compare_pipe
interface fp_compare_pipe_if #(
  parameter int W     = 32,
  parameter int TAG_W = 5
);
  logic             in_valid;
  logic             in_ready;
  logic [2:0]       op;
  logic [W-1:0]     rs1;
  logic [W-1:0]     rs2;
  logic [TAG_W-1:0] tag_in;
  logic             out_valid;
  logic             out_ready;
  logic [W-1:0]     out;
  logic             nv;
  logic [TAG_W-1:0] tag_out;

  modport slave (
    input  in_valid, op, rs1, rs2, tag_in, out_ready,
    output in_ready, out_valid, out, nv, tag_out
  );

  modport master (
    output in_valid, op, rs1, rs2, tag_in, out_ready,
    input  in_ready, out_valid, out, nv, tag_out
  );
endinterface

// File: rtl/fp_compare_pipe.sv
// rtl/fp_compare_pipe.sv - two-stage IEEE-754 FEQ/FLT/FLE/FMIN/FMAX pipeline
module fp_compare_pipe #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23,
  parameter int TAG_W = 5
) (
  input  logic             clk,
  input  logic             resetn,
  fp_compare_pipe_if.slave bus
);
  localparam int W = 1 + EXP_W + MAN_W;

  localparam logic [2:0] OP_FEQ  = 3'd0;
  localparam logic [2:0] OP_FLT  = 3'd1;
  localparam logic [2:0] OP_FLE  = 3'd2;
  localparam logic [2:0] OP_FMIN = 3'd3;
  localparam logic [2:0] OP_FMAX = 3'd4;

  localparam logic [W-1:0] SIGN_BIT  = {1'b1, {(W-1){1'b0}}};
  localparam logic [W-1:0] CANON_NAN = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};

  // Operand classification and sign-magnitude keys, computed ahead of S1
  logic         a_nan, b_nan, a_snan, b_snan, a_zero, b_zero;
  logic [W-1:0] key_a, key_b;

  always_comb begin
    a_nan  = (&bus.rs1[W-2:MAN_W]) && (|bus.rs1[MAN_W-1:0]);
    b_nan  = (&bus.rs2[W-2:MAN_W]) && (|bus.rs2[MAN_W-1:0]);
    a_snan = a_nan && !bus.rs1[MAN_W-1];
    b_snan = b_nan && !bus.rs2[MAN_W-1];
    a_zero = ~|bus.rs1[W-2:0];
    b_zero = ~|bus.rs2[W-2:0];
    key_a  = bus.rs1[W-1] ? ~bus.rs1 : (bus.rs1 | SIGN_BIT);
    key_b  = bus.rs2[W-1] ? ~bus.rs2 : (bus.rs2 | SIGN_BIT);
  end

  logic             s1_valid;
  logic [2:0]       s1_op;
  logic [W-1:0]     s1_a, s1_b;
  logic [TAG_W-1:0] s1_tag;
  logic             s1_a_nan, s1_b_nan, s1_a_snan, s1_b_snan, s1_a_zero, s1_b_zero;
  logic             s1_lt, s1_eq;

  logic             s2_valid;
  logic [W-1:0]     s2_out;
  logic             s2_nv;
  logic [TAG_W-1:0] s2_tag;

  logic s2_can, s1_can;
  assign s2_can       = !s2_valid || bus.out_ready;
  assign s1_can       = !s1_valid || s2_can;
  assign bus.in_ready = s1_can;

  // Final result from the registered classification
  logic [W-1:0] res;
  logic         res_nv;
  logic         any_nan, any_snan, both_zero, is_eq;

  always_comb begin
    res       = '0;
    res_nv    = 1'b0;
    any_nan   = s1_a_nan || s1_b_nan;
    any_snan  = s1_a_snan || s1_b_snan;
    both_zero = s1_a_zero && s1_b_zero;
    is_eq     = s1_eq || both_zero;
    case (s1_op)
      OP_FEQ: begin
        res[0] = !any_nan && is_eq;
        res_nv = any_snan;
      end
      OP_FLT: begin
        res[0] = !any_nan && s1_lt && !both_zero;
        res_nv = any_nan;
      end
      OP_FLE: begin
        res[0] = !any_nan && (s1_lt || is_eq);
        res_nv = any_nan;
      end
      OP_FMIN, OP_FMAX: begin
        res_nv = any_snan;
        if (s1_a_nan && s1_b_nan)
          res = CANON_NAN;
        else if (s1_a_nan)
          res = s1_b;
        else if (s1_b_nan)
          res = s1_a;
        else if (s1_op == OP_FMIN)
          res = s1_lt ? s1_a : s1_b;  // key order already puts -0 below +0
        else
          res = s1_lt ? s1_b : s1_a;
      end
      default: begin
        res    = '0;
        res_nv = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (resetn) begin
      s1_valid <= 1'b0;
      s2_valid <= 1'b0;
      s2_out   <= '0;
      s2_nv    <= 1'b0;
      s2_tag   <= '0;
    end else begin
      if (s1_can) begin
        s1_valid <= bus.in_valid;
        if (bus.in_valid) begin
          s1_op     <= bus.op;
          s1_a      <= bus.rs1;
          s1_b      <= bus.rs2;
          s1_tag    <= bus.tag_in;
          s1_a_nan  <= a_nan;
          s1_b_nan  <= b_nan;
          s1_a_snan <= a_snan;
          s1_b_snan <= b_snan;
          s1_a_zero <= a_zero;
          s1_b_zero <= b_zero;
          s1_lt     <= key_a < key_b;
          s1_eq     <= key_a == key_b;
        end
      end
      if (s2_can) begin
        s2_valid <= s1_valid;
        if (s1_valid) begin
          s2_out <= res;
          s2_nv  <= res_nv;
          s2_tag <= s1_tag;
        end
      end
    end
  end

  assign bus.out_valid = s2_valid;
  assign bus.out       = s2_out;
  assign bus.nv        = s2_nv;
  assign bus.tag_out   = s2_tag;
endmodule

// File: tb/tb_fp_compare_pipe.sv
// tb/tb_fp_compare_pipe.sv - scoreboard bench for fp_compare_pipe (single and double precision)
module tb_fp_compare_pipe;
  logic clk = 1'b0;
  logic resetn = 1'b1;
  always #5 clk = ~clk;

  fp_compare_pipe_if #(.W(32), .TAG_W(5)) sbus ();
  fp_compare_pipe_if #(.W(64), .TAG_W(5)) dbus ();

  fp_compare_pipe #(.EXP_W(8), .MAN_W(23), .TAG_W(5)) dut (
    .clk(clk), .resetn(resetn), .bus(sbus.slave)
  );
  fp_compare_pipe #(.EXP_W(11), .MAN_W(52), .TAG_W(5)) dut64 (
    .clk(clk), .resetn(resetn), .bus(dbus.slave)
  );

  typedef struct {
    logic [31:0] out;
    logic        nv;
    logic [4:0]  tag;
  } exp_t;

  exp_t sbq[$];
  int checks = 0;
  int failures = 0;
  int ready_mode = 0;
  int pcnt = 0;
  bit xfer;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic less_mag(input logic [31:0] a, input logic [31:0] b);
    if (a[30:0] == 0 && b[30:0] == 0) return 1'b0;
    if (a[31] != b[31]) return a[31];
    if (!a[31]) return a[30:0] < b[30:0];
    return a[30:0] > b[30:0];
  endfunction

  function automatic logic [32:0] model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    logic an, bn, as, bs, az, bz, eq, lt;
    logic [31:0] r;
    logic v;
    an = a[30:23] == 8'hFF && a[22:0] != 0;
    bn = b[30:23] == 8'hFF && b[22:0] != 0;
    as = an && !a[22];
    bs = bn && !b[22];
    az = a[30:0] == 0;
    bz = b[30:0] == 0;
    eq = (az && bz) || a == b;
    lt = less_mag(a, b);
    r = 32'h0;
    v = 1'b0;
    case (op)
      3'd0: begin r[0] = !an && !bn && eq; v = as || bs; end
      3'd1: begin r[0] = !an && !bn && lt; v = an || bn; end
      3'd2: begin r[0] = !an && !bn && (lt || eq); v = an || bn; end
      3'd3, 3'd4: begin
        v = as || bs;
        if (an && bn) r = 32'h7FC00000;
        else if (an) r = b;
        else if (bn) r = a;
        else if (az && bz) r = (op == 3'd3) ? (a[31] ? a : b) : (a[31] ? b : a);
        else if (op == 3'd3) r = lt ? a : b;
        else r = lt ? b : a;
      end
      default: begin r = 32'h0; v = 1'b0; end
    endcase
    return {v, r};
  endfunction

  task automatic mon();
    exp_t e;
    logic [32:0] m;
    xfer = 1'b0;
    if (resetn) return;
    if (sbus.out_valid) begin
      if (sbq.size() == 0) check("unexpected_out", 64'd1, 64'd0);
      else if (sbus.out_ready) begin
        e = sbq.pop_front();
        check("out", sbus.out, e.out);
        check("nv", sbus.nv, e.nv);
        check("tag", sbus.tag_out, e.tag);
      end else begin
        e = sbq[0];
        check("stall_out", {sbus.out, sbus.nv, sbus.tag_out}, {e.out, e.nv, e.tag});
      end
    end
    if (sbus.in_valid && sbus.in_ready) begin
      m = model(sbus.op, sbus.rs1, sbus.rs2);
      e.out = m[31:0];
      e.nv = m[32];
      e.tag = sbus.tag_in;
      sbq.push_back(e);
      xfer = 1'b1;
    end
  endtask

  task automatic after_edge();
    @(posedge clk);
    #1;
    pcnt++;
    case (ready_mode)
      0: sbus.out_ready = 1'b1;
      1: sbus.out_ready = (pcnt % 3 == 0);
      2: sbus.out_ready = 1'($urandom_range(0, 1));
      default: sbus.out_ready = 1'b0;
    endcase
  endtask

  task automatic cycle();
    @(negedge clk);
    mon();
    after_edge();
  endtask

  task automatic send(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b, input logic [4:0] tag);
    int n = 0;
    sbus.in_valid = 1'b1;
    sbus.op = op;
    sbus.rs1 = a;
    sbus.rs2 = b;
    sbus.tag_in = tag;
    do begin
      cycle();
      n++;
    end while (!xfer && n < 50);
    if (!xfer) check("send_timeout", 64'd0, 64'd1);
  endtask

  task automatic drain();
    int n = 0;
    sbus.in_valid = 1'b0;
    while (sbq.size() > 0 && n < 200) begin
      cycle();
      n++;
    end
    check("drain_empty", sbq.size(), 0);
  endtask

  // Beat accepted at edge N: out_valid low after N+1, high after N+2
  task automatic lat_check(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b, input logic [4:0] tag);
    ready_mode = 0;
    sbus.out_ready = 1'b1;
    send(op, a, b, tag);
    sbus.in_valid = 1'b0;
    @(negedge clk);
    check("lat_n1", sbus.out_valid, 0);
    mon();
    after_edge();
    @(negedge clk);
    check("lat_n2", sbus.out_valid, 1);
    mon();
    after_edge();
  endtask

  logic [31:0] pool [12] = '{32'h00000000, 32'h80000000, 32'h3F800000, 32'hBF800000,
                              32'h7F800000, 32'hFF800000, 32'h7FC00000, 32'h7F800001,
                              32'hFFC00000, 32'h00000001, 32'h80000001, 32'h40000000};

  function automatic logic [31:0] rand_op();
    if ($urandom_range(0, 1) == 0) return pool[$urandom_range(0, 11)];
    return $urandom;
  endfunction

  initial begin
    logic [63:0] d_a [2] = '{64'hBFF0000000000000, 64'h3FF0000000000000};
    logic [63:0] d_b [2] = '{64'h3FF0000000000000, 64'hBFF0000000000000};
    logic [2:0]  d_op [2] = '{3'd1, 3'd3};
    logic [63:0] d_exp [2] = '{64'h1, 64'hBFF0000000000000};
    int n;

    sbus.in_valid = 1'b0; sbus.op = '0; sbus.rs1 = '0; sbus.rs2 = '0; sbus.tag_in = '0;
    sbus.out_ready = 1'b1;
    dbus.in_valid = 1'b0; dbus.op = '0; dbus.rs1 = '0; dbus.rs2 = '0; dbus.tag_in = '0;
    dbus.out_ready = 1'b1;

    resetn = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    check("rst_out_valid", sbus.out_valid, 0);
    check("rst_out", sbus.out, 0);
    check("rst_nv", sbus.nv, 0);
    check("rst_tag", sbus.tag_out, 0);
    check("rst_in_ready", sbus.in_ready, 1);
    @(posedge clk);
    #1;
    resetn = 1'b0;

    lat_check(3'd2, 32'h3F800000, 32'h40000000, 5'd1);

    send(3'd2, 32'h40000000, 32'h3F800000, 5'd2);
    send(3'd0, 32'h80000000, 32'h00000000, 5'd3);
    send(3'd3, 32'h80000000, 32'h00000000, 5'd4);
    send(3'd4, 32'h80000000, 32'h00000000, 5'd5);
    send(3'd1, 32'h7FC00000, 32'h3F800000, 5'd6);
    send(3'd0, 32'h7FC00000, 32'h3F800000, 5'd7);
    send(3'd0, 32'h7F800001, 32'h3F800000, 5'd8);
    send(3'd4, 32'h7F800001, 32'h7FC00000, 5'd9);
    send(3'd6, 32'h3F800000, 32'h3F800000, 5'd10);
    drain();

    ready_mode = 1;
    pcnt = 0;
    for (int i = 0; i < 6; i++)
      send(3'd2, 32'h3F800000 + 32'(i), 32'h3F800003, 5'(i));
    drain();

    ready_mode = 2;
    for (int i = 0; i < 300; i++) begin
      send(3'($urandom_range(0, 7)), rand_op(), rand_op(), 5'($urandom));
      if ($urandom_range(0, 3) == 0) begin
        sbus.in_valid = 1'b0;
        cycle();
      end
    end
    drain();

    ready_mode = 3;
    sbus.out_ready = 1'b0;
    send(3'd1, 32'h3F800000, 32'h40000000, 5'd20);
    send(3'd1, 32'h40000000, 32'h3F800000, 5'd21);
    sbus.tag_in = 5'd22;
    @(negedge clk);
    check("full_in_ready", sbus.in_ready, 0);
    mon();
    after_edge();
    resetn = 1'b1;
    cycle();
    sbq.delete();
    @(negedge clk);
    check("midrst_out_valid", sbus.out_valid, 0);
    check("midrst_out", sbus.out, 0);
    check("midrst_in_ready", sbus.in_ready, 1);
    after_edge();
    resetn = 1'b0;
    sbus.in_valid = 1'b0;
    lat_check(3'd0, 32'h3F800000, 32'h3F800000, 5'd23);
    drain();

    for (int k = 0; k < 2; k++) begin
      dbus.in_valid = 1'b1;
      dbus.op = d_op[k];
      dbus.rs1 = d_a[k];
      dbus.rs2 = d_b[k];
      dbus.tag_in = 5'(k + 3);
      @(posedge clk);
      #1;
      dbus.in_valid = 1'b0;
      n = 0;
      @(negedge clk);
      while (!dbus.out_valid && n < 10) begin
        @(negedge clk);
        n++;
      end
      check("dp_valid", dbus.out_valid, 1);
      check("dp_out", dbus.out, d_exp[k]);
      check("dp_nv", dbus.nv, 0);
      check("dp_tag", dbus.tag_out, 64'(k + 3));
      @(posedge clk);
      #1;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/fp_compare_pipe.md
# fp_compare_pipe

Parametrised, pipelined IEEE-754 compare/min/max unit for the float datapath. It executes FEQ, FLT, FLE, FMIN and FMAX on any binary format set by EXP_W/MAN_W. It is generalised from the single-precision set-less-or-equal compare and adds correct NaN classification, invalid-flag generation, +0/-0 handling and a two-stage valid/ready pipeline with backpressure. It sits between the float operand-read stage and writeback, and carries an opaque tag so results can be retired to the correct destination.

## Interface
- EXP_W, default 8: exponent width.
- MAN_W, default 23: stored mantissa width. Operand width W = 1+EXP_W+MAN_W.
- TAG_W, default 5: opaque tag width, typically the destination register index.
- clk  in  1  clock; all state updates on the rising edge.
- resetn  in  1  reset, synchronous and active-high: the block is reset on a rising clk edge while resetn=1.
- in_valid  in  1  operand beat valid.
- in_ready  out  1  block accepts a beat this cycle.
- op  in  3  operation: 0=FEQ, 1=FLT, 2=FLE, 3=FMIN, 4=FMAX. Values 5-7 are reserved and produce result 0 with nv=0.
- rs1, rs2  in  W  operands.
- tag_in  in  TAG_W  tag.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts the result.
- out  out  W  result. Compares return zero-extended 1/0; min/max return a W-bit float.
- nv  out  1  invalid-operation flag for this result.
- tag_out  out  TAG_W  tag of this result.

## Operation
- Classification per operand:
  - NaN: exponent all ones and mantissa != 0.
  - sNaN: NaN with mantissa MSB = 0.
  - zero: exponent = 0 and mantissa = 0.
- Ordering uses sign-magnitude. Map each operand to key = sign ? ~x : x|MSB, then compare keys unsigned.
  - +0 and -0 compare equal for FEQ, FLT and FLE.
- FEQ:
  - Result = 1 if neither operand is NaN and (keys are equal or both operands are zero).
  - nv = 1 if either operand is an sNaN.
- FLT and FLE:
  - Result = 0 if either operand is NaN.
  - nv = 1 if either operand is NaN, quiet or signalling.
- FMIN and FMAX:
  - Both operands NaN: result is canonical NaN {0, all-ones exponent, 1, zeros}.
  - Exactly one operand NaN: result is the other operand.
  - Otherwise result is the smaller (FMIN) or larger (FMAX) value. -0 is treated as less than +0.
  - nv = 1 if either operand is an sNaN.
- Pipeline has two register stages, S1 and S2:
  - S1 captures the operands, op and tag, and registers the NaN, sNaN and zero classification plus the key compare.
  - S2 holds the final out, nv and tag.
- Each stage holds a valid bit. A stage loads when it is empty or its contents move downstream in the same cycle.
  - in_ready = !s1_valid || !s2_valid || out_ready. This is combinational and has no dependency on in_valid.
  - A beat transfers when in_valid && in_ready. A result is consumed when out_valid && out_ready.
- Reset: s1_valid and s2_valid clear to 0. out, nv and tag_out clear to 0.
- While resetn=1, any in-flight beats are discarded and in_valid is ignored.
- out, nv and tag_out must hold stable while out_valid=1 and out_ready=0.

## Timing
- Latency: a beat accepted at edge N appears with out_valid=1 after edge N+2, given no stall.
- Throughput: one beat per cycle while out_ready is held at 1.
- Stall behaviour:
  - When out_ready=0 with S2 full, S1 can still fill. in_ready then drops the cycle after S1 becomes full.
  - No beat is dropped or duplicated.
- Simultaneous events: when S2 is consumed, S1 advances into S2 and a new beat enters S1, all on the same edge.
- Reset takes priority over any transfer on the same edge.
- Reset value after the edge: out_valid=0. in_ready=1 is reached combinationally.

## Test plan
- FLE, single precision:
  - rs1=0x3F800000 (1.0), rs2=0x40000000 (2.0) -> out=1, nv=0 after two edges.
  - Operands swapped -> out=0.
- Signed zeros:
  - FEQ 0x80000000 vs 0x00000000 -> out=1, nv=0.
  - FMIN of the same pair -> out=0x80000000.
  - FMAX of the same pair -> out=0x00000000.
- NaN handling:
  - FLT 0x7FC00000 vs 0x3F800000 -> out=0, nv=1.
  - FEQ with the same operands -> out=0, nv=0.
  - FEQ with 0x7F800001 (sNaN) -> nv=1.
  - FMAX 0x7F800001 vs 0x7FC00000 -> out=0x7FC00000, nv=1.
- Backpressure: stream 6 beats with tags 0-5 while out_ready toggles 1,0,0,1,... -> tags appear in order 0-5, each exactly once, and outputs stay stable during stalls.
- Reset mid-stream: assert resetn=1 for one edge with both stages full -> next cycle out_valid=0 and out=0, and a subsequent beat returns its result after 2 edges.
- Parametric check: EXP_W=11, MAN_W=52, FLT 0xBFF0000000000000 (-1.0) vs 0x3FF0000000000000 (1.0) -> out=1, nv=0.
